fp_convert: RTL and testbench

Pipelined IEEE-754 single-precision to signed fixed-point converter. It feeds the CORDIC angle datapath: a float input angle is converted into the Q(INTEGER_WIDTH.FRACTIONAL_WIDTH) two's-complement format used by the CORDIC iteration registers. The pipeline advances only on enabled cycles, so the controller can freeze it with `clk_en`.

---
 rtl/cordic_pkg.sv | 28 ++
 rtl/fp_align_shift.sv | 38 +++
 rtl/fp_convert.sv | 129 ++++++++++++
 tb/tb_fp_convert.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared widths, float field constants and fixed-point types for the CORDIC datapath
package cordic_pkg;
    localparam int INTEGER_WIDTH     = 4;
    localparam int FRACTIONAL_WIDTH  = 20;
    localparam int CORDIC_DATA_WIDTH = INTEGER_WIDTH + FRACTIONAL_WIDTH;
    localparam int FLOAT_DATA_WIDTH  = 32;

    localparam int EXP_WIDTH  = 8;
    localparam int MANT_WIDTH = 23;
    localparam int SIG_WIDTH  = MANT_WIDTH + 1;
    localparam int EXP_BIAS   = 127;
    localparam logic [EXP_WIDTH-1:0] EXP_ALL_ONES = 8'd255;

    // Signed alignment shift: covers e-127-23+FRACTIONAL_WIDTH for every normal exponent
    localparam int SHIFT_WIDTH = 10;

    typedef logic signed [CORDIC_DATA_WIDTH-1:0] fixed_t;

    localparam fixed_t FIXED_MAX = {1'b0, {(CORDIC_DATA_WIDTH-1){1'b1}}};
    localparam fixed_t FIXED_MIN = {1'b1, {(CORDIC_DATA_WIDTH-1){1'b0}}};

    // CLASS_NULL covers zero, subnormal and NaN: all of them convert to 0
    typedef enum logic [1:0] {
        CLASS_NULL   = 2'd0,
        CLASS_NORMAL = 2'd1,
        CLASS_INF    = 2'd2
    } float_class_t;
endpackage

// File: rtl/fp_align_shift.sv
// rtl/fp_align_shift.sv - combinational significand alignment shifter with truncation and overflow flag
module fp_align_shift #(
    parameter int SIG_W   = 24,
    parameter int OUT_W   = 24,
    parameter int SHIFT_W = 10
) (
    input  logic [SIG_W-1:0]          significand,
    input  logic signed [SHIFT_W-1:0] shift,
    output logic [OUT_W-1:0]          magnitude,
    output logic                      overflow
);
    localparam int WIDE_W = SIG_W + OUT_W;

    logic [WIDE_W-1:0]  wide;
    logic [SHIFT_W-1:0] right_amount;

    assign right_amount = -shift;

    always_comb begin
        wide      = '0;
        magnitude = '0;
        overflow  = 1'b0;
        if (!shift[SHIFT_W-1]) begin
            // Shifts past the output width would drop the leading bits off the wide bus
            if (shift >= SHIFT_W'(OUT_W)) begin
                overflow = |significand;
            end else begin
                wide      = WIDE_W'(significand) << shift;
                magnitude = wide[OUT_W-1:0];
                overflow  = |wide[WIDE_W-1:OUT_W];
            end
        end else begin
            wide      = WIDE_W'(significand) >> right_amount;
            magnitude = wide[OUT_W-1:0];
            overflow  = |wide[WIDE_W-1:OUT_W];
        end
    end
endmodule

// File: rtl/fp_convert.sv
// rtl/fp_convert.sv - 3-stage IEEE-754 single to signed fixed-point converter; optional FP_CONVERT_OVERFLOW_EN adds overflow output
module fp_convert #(
    parameter int FLOAT_DATA_WIDTH = 32,
    parameter int INTEGER_WIDTH    = 4,
    parameter int FRACTIONAL_WIDTH = 20
) (
    input  logic                                      clock,
    input  logic                                      aclr,
    input  logic                                      clk_en,
    input  logic [FLOAT_DATA_WIDTH-1:0]               dataa,
    output logic [INTEGER_WIDTH+FRACTIONAL_WIDTH-1:0] result
`ifdef FP_CONVERT_OVERFLOW_EN
    ,
    output logic                                      overflow
`endif
);
    import cordic_pkg::*;

    localparam int W = INTEGER_WIDTH + FRACTIONAL_WIDTH;
    localparam logic [SHIFT_WIDTH-1:0] SHIFT_OFFSET = SHIFT_WIDTH'(EXP_BIAS + MANT_WIDTH - FRACTIONAL_WIDTH);
    localparam logic [W-1:0] SAT_MAX   = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_MIN   = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] NEG_LIMIT = {1'b1, {(W-1){1'b0}}};

    logic                  in_sign;
    logic [EXP_WIDTH-1:0]  in_exp;
    logic [MANT_WIDTH-1:0] in_mant;
    float_class_t          in_class;

    logic                   s1_sign;
    float_class_t           s1_class;
    logic [SIG_WIDTH-1:0]   s1_sig;
    logic [SHIFT_WIDTH-1:0] s1_shift;

    logic [W-1:0] align_mag;
    logic         align_ovf;
    logic [W-1:0] s2_mag_next;
    logic         s2_sat_next;

    logic         s2_sign;
    logic         s2_sat;
    logic [W-1:0] s2_mag;

    assign in_sign = dataa[FLOAT_DATA_WIDTH-1];
    assign in_exp  = dataa[FLOAT_DATA_WIDTH-2 -: EXP_WIDTH];
    assign in_mant = dataa[MANT_WIDTH-1:0];

    always_comb begin
        in_class = CLASS_NORMAL;
        if (in_exp == '0) begin
            in_class = CLASS_NULL;
        end else if (in_exp == EXP_ALL_ONES) begin
            in_class = (in_mant == '0) ? CLASS_INF : CLASS_NULL;
        end
    end

    always_ff @(posedge clock) begin
        if (aclr) begin
            s1_sign  <= 1'b0;
            s1_class <= CLASS_NULL;
            s1_sig   <= '0;
            s1_shift <= '0;
        end else if (clk_en) begin
            s1_sign  <= in_sign;
            s1_class <= in_class;
            s1_sig   <= {1'b1, in_mant};
            s1_shift <= SHIFT_WIDTH'(in_exp) - SHIFT_OFFSET;
        end
    end

    fp_align_shift #(
        .SIG_W   (SIG_WIDTH),
        .OUT_W   (W),
        .SHIFT_W (SHIFT_WIDTH)
    ) u_align (
        .significand (s1_sig),
        .shift       (s1_shift),
        .magnitude   (align_mag),
        .overflow    (align_ovf)
    );

    // Negative side may reach exactly 2^(W-1); positive side stops one below
    always_comb begin
        s2_mag_next = '0;
        s2_sat_next = 1'b0;
        case (s1_class)
            CLASS_NORMAL: begin
                s2_mag_next = align_mag;
                s2_sat_next = align_ovf | (s1_sign ? (align_mag > NEG_LIMIT) : align_mag[W-1]);
            end
            CLASS_INF: s2_sat_next = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (aclr) begin
            s2_sign <= 1'b0;
            s2_sat  <= 1'b0;
            s2_mag  <= '0;
        end else if (clk_en) begin
            s2_sign <= s1_sign;
            s2_sat  <= s2_sat_next;
            s2_mag  <= s2_mag_next;
        end
    end

    always_ff @(posedge clock) begin
        if (aclr) begin
            result <= '0;
        end else if (clk_en) begin
            if (s2_sat) begin
                result <= s2_sign ? SAT_MIN : SAT_MAX;
            end else begin
                result <= s2_sign ? -s2_mag : s2_mag;
            end
        end
    end

`ifdef FP_CONVERT_OVERFLOW_EN
    always_ff @(posedge clock) begin
        if (aclr) begin
            overflow <= 1'b0;
        end else if (clk_en) begin
            overflow <= s2_sat;
        end
    end
`endif
endmodule

// File: tb/tb_fp_convert.sv
// tb/tb_fp_convert.sv - directed self-checking bench for fp_convert (covers FP_CONVERT_OVERFLOW_EN when defined)
module tb_fp_convert;
    logic        clock;
    logic        aclr;
    logic        clk_en;
    logic [31:0] dataa;
    logic [23:0] result;
`ifdef FP_CONVERT_OVERFLOW_EN
    logic        overflow;
`endif

    int checks;
    int failures;

    typedef struct {
        string       tag;
        logic [31:0] din;
        logic [23:0] exp_result;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[18];

    fp_convert dut (
        .clock    (clock),
        .aclr     (aclr),
        .clk_en   (clk_en),
        .dataa    (dataa),
        .result   (result)
`ifdef FP_CONVERT_OVERFLOW_EN
        ,
        .overflow (overflow)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%06h expected 0x%06h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        aclr     = 1'b1;
        clk_en   = 1'b0;
        dataa    = 32'h0;

        vecs[0]  = '{"one",        32'h3F800000, 24'h100000, 1'b0};
        vecs[1]  = '{"pi_4",       32'h3F490FDB, 24'h0C90FD, 1'b0};
        vecs[2]  = '{"neg_pi_4",   32'hBF490FDB, 24'hF36F03, 1'b0};
        vecs[3]  = '{"ten",        32'h41200000, 24'h7FFFFF, 1'b1};
        vecs[4]  = '{"neg_ten",    32'hC1200000, 24'h800000, 1'b1};
        vecs[5]  = '{"pos_inf",    32'h7F800000, 24'h7FFFFF, 1'b1};
        vecs[6]  = '{"neg_inf",    32'hFF800000, 24'h800000, 1'b1};
        vecs[7]  = '{"zero",       32'h00000000, 24'h000000, 1'b0};
        vecs[8]  = '{"neg_zero",   32'h80000000, 24'h000000, 1'b0};
        vecs[9]  = '{"tiny",       32'h33D6BF95, 24'h000000, 1'b0};
        vecs[10] = '{"nan",        32'h7FC00000, 24'h000000, 1'b0};
        vecs[11] = '{"neg_eight",  32'hC1000000, 24'h800000, 1'b0};
        vecs[12] = '{"pos_eight",  32'h41000000, 24'h7FFFFF, 1'b1};
        vecs[13] = '{"max_below8", 32'h40FFFFFF, 24'h7FFFFF, 1'b0};
        vecs[14] = '{"lsb",        32'h35800000, 24'h000001, 1'b0};
        vecs[15] = '{"huge",       32'h4F000000, 24'h7FFFFF, 1'b1};
        vecs[16] = '{"subnormal",  32'h00400000, 24'h000000, 1'b0};
        vecs[17] = '{"neg_one",    32'hBF800000, 24'hF00000, 1'b0};

        step();
        step();
        check("reset_result", 32'(result), 32'h0);
`ifdef FP_CONVERT_OVERFLOW_EN
        check("reset_overflow", 32'(overflow), 32'h0);
`endif
        aclr   = 1'b0;
        clk_en = 1'b1;

        foreach (vecs[i]) begin
            dataa = vecs[i].din;
            repeat (3) step();
            check(vecs[i].tag, 32'(result), 32'(vecs[i].exp_result));
`ifdef FP_CONVERT_OVERFLOW_EN
            check({vecs[i].tag, "_ovf"}, 32'(overflow), 32'(vecs[i].exp_ovf));
`endif
        end

        // Flush to zero so the stream starts from a known state
        dataa = 32'h0;
        repeat (3) step();

        // Back-to-back stream with a two-cycle freeze
        dataa = 32'h3F800000; step();
        dataa = 32'h3F490FDB; step();
        dataa = 32'hBF800000; step();
        check("stream_first", 32'(result), 32'h100000);
        clk_en = 1'b0;
        dataa  = 32'h41200000;
        step();
        check("hold_1", 32'(result), 32'h100000);
        step();
        check("hold_2", 32'(result), 32'h100000);
        clk_en = 1'b1;
        dataa  = 32'h0;
        step();
        check("stream_second", 32'(result), 32'h0C90FD);
        step();
        check("stream_third", 32'(result), 32'hF00000);
        step();
        check("frozen_input_ignored", 32'(result), 32'h0);

        // Reset mid-stream, with clk_en low to show reset wins
        dataa = 32'h3F800000; step();
        dataa = 32'h3F490FDB; step();
        dataa = 32'hBF800000; step();
        check("pre_reset", 32'(result), 32'h100000);
        aclr   = 1'b1;
        clk_en = 1'b0;
        step();
        check("reset_mid_stream", 32'(result), 32'h0);
        aclr   = 1'b0;
        clk_en = 1'b1;
        dataa  = 32'h3F800000;
        step();
        check("flushed_1", 32'(result), 32'h0);
        dataa = 32'h0;
        step();
        check("flushed_2", 32'(result), 32'h0);
        step();
        check("post_reset_first", 32'(result), 32'h100000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
